// File: rtl/f3m_mult_pkg.sv
// -----------------------------------------------------------------------------
// f3m_mult_pkg
// Shared constants, types and GF(3) helpers for the bit-serial GF(3^97)
// multiplier. Field elements are packed two bits per trit, trit i at bits
// [2i+1:2i], with encoding 00 = 0, 01 = 1, 10 = 2 (11 is never produced).
// -----------------------------------------------------------------------------
package f3m_mult_pkg;

  localparam int M     = 97;
  localparam int WIDTH = 2 * M - 1;
  localparam int TAP   = 12;          // middle term of x^97 + x^12 + 2

  localparam logic [WIDTH:0] ZERO = '0;

  // Low-order part of the modulus (PX without its leading x^97 term):
  // trit 12 = 1, trit 0 = 2.
  localparam logic [WIDTH:0] PX = (WIDTH+1)'(2'b01) << (2 * TAP) | (WIDTH+1)'(2'b10);

  localparam logic [1:0] TRIT_0 = 2'b00;
  localparam logic [1:0] TRIT_1 = 2'b01;
  localparam logic [1:0] TRIT_2 = 2'b10;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Per-trit GF(3) addition; the encoding equals the trit's binary value.
  function automatic logic [1:0] f3_add(input logic [1:0] x, input logic [1:0] y);
    logic [2:0] s;
    s = {1'b0, x} + {1'b0, y};
    return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
  endfunction

  // Multiplication of one trit by 2 is a hi/lo swap (1 <-> 2, 0 stays 0).
  function automatic logic [1:0] f3_dbl(input logic [1:0] x);
    return {x[0], x[1]};
  endfunction

endpackage

// File: rtl/f3m_mult_if.sv
// -----------------------------------------------------------------------------
// f3m_mult_if
// Operation handshake of the GF(3^97) multiplier.
//   start : request a multiply (sampled only when the block is idle)
//   a, b  : operands, trit-packed
//   c     : registered product a*b mod PX
//   done  : one-cycle pulse after c is updated
//   busy  : high while an operation is in progress
// master = requester, slave = multiplier.
// -----------------------------------------------------------------------------
interface f3m_mult_if;
  import f3m_mult_pkg::*;

  logic             start;
  logic [WIDTH:0]   a;
  logic [WIDTH:0]   b;
  logic [WIDTH:0]   c;
  logic             done;
  logic             busy;

  modport master (output start, a, b, input  c, done, busy);
  modport slave  (input  start, a, b, output c, done, busy);

endinterface

// File: rtl/f3m_mult_step.sv
// -----------------------------------------------------------------------------
// f3m_mult_step
// One Horner step over GF(3^97), purely combinational:
//   y = (x * acc mod PX) + t * a
// Ports:
//   acc : running accumulator
//   a   : multiplicand
//   t   : current multiplier trit
//   y   : next accumulator value
// No carries: every operation is trit-local, so the path is one shift,
// one scaling mux and one row of GF(3) adders.
// -----------------------------------------------------------------------------
module f3m_mult_step
  import f3m_mult_pkg::*;
(
  input  logic [WIDTH:0] acc,
  input  logic [WIDTH:0] a,
  input  logic [1:0]     t,
  output logic [WIDTH:0] y
);

  logic [1:0]     h;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] scaled;

  // x*acc: shift up one trit; the outgoing top trit h re-enters as
  // h into trit 0 and 2h into trit 12, since x^97 == 2x^12 + 1.
  always_comb begin
    h       = acc[WIDTH -: 2];
    shifted = {acc[WIDTH-2:0], h};
    shifted[2*TAP +: 2] = f3_add(acc[2*TAP-2 +: 2], f3_dbl(h));
  end

  // t*a: zero, pass-through, or hi/lo swap in every trit.
  always_comb begin
    scaled = ZERO;
    case (t)
      TRIT_1:  scaled = a;
      TRIT_2: begin
        for (int i = 0; i < M; i++) scaled[2*i +: 2] = f3_dbl(a[2*i +: 2]);
      end
      default: scaled = ZERO;
    endcase
  end

  always_comb begin
    y = ZERO;
    for (int i = 0; i < M; i++) y[2*i +: 2] = f3_add(shifted[2*i +: 2], scaled[2*i +: 2]);
  end

endmodule

// File: rtl/f3m_mult.sv
// -----------------------------------------------------------------------------
// f3m_mult
// Bit-serial GF(3^97) multiplier, reduced modulo x^97 + x^12 + 2.
// MSB-first Horner: one multiplier trit per cycle, product after 97 cycles,
// then c is held until the next operation completes.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous, active-low reset
//   bus   : f3m_mult_if.slave (start, a, b in; c, done, busy out)
// -----------------------------------------------------------------------------
module f3m_mult
  import f3m_mult_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  f3m_mult_if.slave     bus
);

  state_e         state_q, state_d;
  logic [6:0]     cnt_q,   cnt_d;
  logic [WIDTH:0] a_r_q,   a_r_d;
  logic [WIDTH:0] b_r_q,   b_r_d;
  logic [WIDTH:0] acc_q,   acc_d;
  logic [WIDTH:0] c_q,     c_d;
  logic           done_q,  done_d;

  logic [7:0]     sel_idx;
  logic [1:0]     cur_trit;
  logic [WIDTH:0] step_y;

  // Trit select b_r[2cnt+1:2cnt].
  assign sel_idx  = {cnt_q, 1'b0};
  assign cur_trit = b_r_q[sel_idx +: 2];

  f3m_mult_step u_step (
    .acc (acc_q),
    .a   (a_r_q),
    .t   (cur_trit),
    .y   (step_y)
  );

  // NOTE: every _d signal gets a default first so no path through this
  // block leaves one unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_r_d   = a_r_q;
    b_r_d   = b_r_q;
    acc_d   = acc_q;
    c_d     = c_q;
    done_d  = 1'b0;            // pulse: cleared on every non-completing edge

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_r_d   = bus.a;
          b_r_d   = bus.b;
          acc_d   = ZERO;
          cnt_d   = 7'(M - 1);
          state_d = RUN;
        end
      end
      RUN: begin
        // start is deliberately not looked at here: it is not queued.
        acc_d = step_y;
        cnt_d = cnt_q - 7'd1;
        if (cnt_q == 7'd0) begin
          c_d     = step_y;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: all state uses non-blocking assignments so every flop samples the
  // pre-edge values; operand latches are reset too, since they are plain
  // registers (not a RAM) and a known value keeps the step logic clean.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 7'd0;
      a_r_q   <= ZERO;
      b_r_q   <= ZERO;
      acc_q   <= ZERO;
      c_q     <= ZERO;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_r_q   <= a_r_d;
      b_r_q   <= b_r_d;
      acc_q   <= acc_d;
      c_q     <= c_d;
      done_q  <= done_d;
    end
  end

  assign bus.c    = c_q;
  assign bus.done = done_q;
  assign bus.busy = (state_q == RUN);

endmodule
